// File: rtl/gpio_switch_in_pkg.sv
// Shared constants for the GPIO switch/button input peripheral: register offsets,
// read-word field positions, debounce defaults and the STATUS word packer.
package gpio_switch_in_pkg;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_PEND   = 1'b1;

  localparam int SW_LSB   = 0;
  localparam int BTN_LSB  = 8;
  localparam int PEND_LSB = 13;
  localparam int MASK_LSB = 18;

  localparam int DB_LIMIT_SYN = 1000000;
  localparam int DB_LIMIT_SIM = 4;
  localparam int DB_CW_DEF    = 20;

  function automatic logic [31:0] pack_status(input logic [7:0] sw,
                                              input logic [4:0] btn,
                                              input logic [4:0] pend,
                                              input logic [4:0] mask);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[SW_LSB +: 8]   = sw;
    v[BTN_LSB +: 5]  = btn;
    v[PEND_LSB +: 5] = pend;
    v[MASK_LSB +: 5] = mask;
    return v;
  endfunction

endpackage

// File: rtl/gpio_switch_in_debounce.sv
// Two-flop synchronizer plus tick-sampled debouncer over a vector of raw pins.
// One tick counter is shared by every bit so all inputs are sampled together.
module gpio_debounce
  import gpio_switch_in_pkg::*;
#(
  parameter int W        = 13,
  parameter int DB_LIMIT = DB_LIMIT_SYN,
  parameter int DB_CW    = DB_CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb
);

  localparam logic [DB_CW-1:0] LP_LAST = DB_CW'(DB_LIMIT - 1);

  logic [DB_CW-1:0] r_cnt;
  logic [W-1:0]     r_sync1;
  logic [W-1:0]     r_sync2;
  logic [W-1:0]     r_samp;
  logic [W-1:0]     r_deb;
  logic             w_tick;
  logic [W-1:0]     w_diff;

  assign w_tick = (r_cnt == LP_LAST);
  assign w_diff = r_sync2 ^ r_samp;
  assign o_deb  = r_deb;

  // Free-running sample tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DB_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit only moves when two consecutive tick samples agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp <= '0;
      r_deb  <= '0;
    end else if (w_tick) begin
      r_samp <= r_sync2;
      r_deb  <= (r_sync2 & ~w_diff) | (r_deb & w_diff);
    end else begin
      r_samp <= r_samp;
      r_deb  <= r_deb;
    end
  end

endmodule

// File: rtl/gpio_switch_in.sv
// Memory-mapped GPIO input block: debounced switches/buttons, sticky press-pending
// bits with W1C and read-to-clear, per-button interrupt mask and a level irq.
module gpio_switch_in
  import gpio_switch_in_pkg::*;
#(
  parameter int SW_W     = 8,
  parameter int BTN_W    = 5,
  parameter int DB_LIMIT = DB_LIMIT_SYN,
  parameter int DB_CW    = DB_CW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [BTN_W-1:0] btn_raw,
  input  logic             addr,
  input  logic             rd_en,
  input  logic             we,
  input  logic [31:0]      Peripheral_in,
  output logic [31:0]      Peripheral_out,
  output logic             irq
);

  logic [SW_W+BTN_W-1:0] w_deb;
  logic [SW_W-1:0]       w_sw_deb;
  logic [BTN_W-1:0]      w_btn_deb;
  logic [BTN_W-1:0]      w_press;
  logic [BTN_W-1:0]      w_w1c;
  logic [BTN_W-1:0]      w_rclr;
  logic [BTN_W-1:0]      w_pend_nxt;
  logic [BTN_W-1:0]      r_btn_d;
  logic [BTN_W-1:0]      r_pend;
  logic [BTN_W-1:0]      r_mask;
  logic                  r_irq;
  logic                  w_unused_in;

  gpio_debounce #(
    .W       (SW_W + BTN_W),
    .DB_LIMIT(DB_LIMIT),
    .DB_CW   (DB_CW)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .i_raw({btn_raw, sw_raw}),
    .o_deb(w_deb)
  );

  assign w_sw_deb    = w_deb[SW_W-1:0];
  assign w_btn_deb   = w_deb[SW_W+BTN_W-1:SW_W];
  assign w_press     = w_btn_deb & ~r_btn_d;
  assign w_unused_in = ^Peripheral_in[31:BTN_W];

  // W1C and read-to-clear merge; a press in the same cycle still sets the bit
  assign w_w1c      = (we && (addr == ADDR_PEND)) ? Peripheral_in[BTN_W-1:0] : {BTN_W{1'b0}};
  assign w_rclr     = (rd_en && (addr == ADDR_PEND)) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};
  assign w_pend_nxt = (r_pend & ~(w_w1c | w_rclr)) | w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_d <= '0;
      r_pend  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_btn_d <= w_btn_deb;
      r_pend  <= w_pend_nxt;
      r_irq   <= |(r_pend & r_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (we && (addr == ADDR_STATUS)) begin
      r_mask <= Peripheral_in[BTN_W-1:0];
    end else begin
      r_mask <= r_mask;
    end
  end

  assign irq = r_irq;

  always_comb begin
    Peripheral_out = 32'h0000_0000;
    case (addr)
      ADDR_STATUS: Peripheral_out = pack_status(8'(w_sw_deb), 5'(w_btn_deb), 5'(r_pend), 5'(r_mask));
      ADDR_PEND:   Peripheral_out = {27'h0, 5'(r_pend)};
      default:     Peripheral_out = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_gpio_switch_in.sv
// Randomized and directed bench for gpio_switch_in with a behavioural model that
// predicts debounced state, pending bits, mask, irq and read data every cycle.
module tb_gpio_switch_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw_raw = 8'h00;
  logic [4:0]  btn_raw = 5'h00;
  logic        addr = 1'b0;
  logic        rd_en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] Peripheral_in = 32'h0;
  logic [31:0] Peripheral_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_switch_in #(.SW_W(8), .BTN_W(5), .DB_LIMIT(4), .DB_CW(20)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw), .addr(addr),
    .rd_en(rd_en), .we(we), .Peripheral_in(Peripheral_in),
    .Peripheral_out(Peripheral_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: inputs are seen 2 clocks late; every 4th clock the pins are sampled and
  // a bit's debounced value follows only when two successive samples agree.
  int          m_cyc;
  logic [12:0] m_d1, m_d2, m_samp, m_deb;
  logic [4:0]  m_btn_d, m_pend, m_mask, m_press, m_clr;
  logic        m_irq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_d1 = '0; m_d2 = '0; m_samp = '0; m_deb = '0;
      m_btn_d = '0; m_pend = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      m_press = m_deb[12:8] & ~m_btn_d;
      m_clr = 5'h00;
      if (we && addr) m_clr = m_clr | Peripheral_in[4:0];
      if (rd_en && addr) m_clr = 5'h1F;
      m_irq = |(m_pend & m_mask);
      m_pend = (m_pend & ~m_clr) | m_press;
      if (we && !addr) m_mask = Peripheral_in[4:0];
      m_btn_d = m_deb[12:8];
      if (m_cyc % 4 == 3) begin
        for (int i = 0; i < 13; i++) if (m_d2[i] == m_samp[i]) m_deb[i] = m_d2[i];
        m_samp = m_d2;
      end
      m_d2 = m_d1;
      m_d1 = {btn_raw, sw_raw};
      m_cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] e;
    e = addr ? {27'h0, m_pend} : {9'h0, m_mask, m_pend, m_deb[12:8], m_deb[7:0]};
    chk("model_out", Peripheral_out, e);
    chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic peek(input logic a, output logic [31:0] v);
    addr = a;
    #1;
    v = Peripheral_out;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    step();
    we = 1'b1; addr = a; Peripheral_in = d;
    step();
    we = 1'b0; Peripheral_in = 32'h0;
  endtask

  task automatic press_btn(input int b);
    btn_raw[b] = 1'b1;
    repeat (14) step();
    btn_raw[b] = 1'b0;
    repeat (14) step();
  endtask

  logic [31:0] v;
  logic        hit;

  initial begin
    repeat (3) step();
    chk("reset_out", Peripheral_out, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // Debounce: steady value propagates, short pulse is dropped
    sw_raw = 8'hA5;
    repeat (12) step();
    peek(1'b0, v); chk("sw_deb_A5", {24'h0, v[7:0]}, 32'hA5);
    sw_raw = 8'hA4;
    repeat (3) step();
    sw_raw = 8'hA5;
    repeat (14) step();
    peek(1'b0, v); chk("glitch_dropped", {24'h0, v[7:0]}, 32'hA5);

    // Press / irq / mask
    wr(1'b0, 32'h04);
    press_btn(2);
    peek(1'b1, v); chk("pend_04", v, 32'h04);
    chk("irq_on", {31'h0, irq}, 32'h1);
    press_btn(0);
    peek(1'b1, v); chk("pend_05", v, 32'h05);
    chk("irq_still_on", {31'h0, irq}, 32'h1);
    peek(1'b0, v); chk("status_word", v, 32'h0010A0A5);
    wr(1'b0, 32'h0);
    chk("irq_lag", {31'h0, irq}, 32'h1);
    step();
    chk("irq_masked", {31'h0, irq}, 32'h0);

    // Read-to-clear returns the pre-clear value
    step();
    addr = 1'b1; rd_en = 1'b1;
    #1 chk("rclr_data", Peripheral_out, 32'h5);
    step();
    rd_en = 1'b0;
    peek(1'b1, v); chk("rclr_cleared", v, 32'h0);

    // W1C colliding with a press: the press wins
    btn_raw[0] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      step();
      if (m_deb[8] && !m_btn_d[0]) begin
        we = 1'b1; addr = 1'b1; Peripheral_in = 32'h01; hit = 1'b1;
      end
    end
    chk("collision_found", {31'h0, hit}, 32'h1);
    step();
    we = 1'b0; Peripheral_in = 32'h0;
    peek(1'b1, v); chk("collision_pend", v, 32'h01);
    btn_raw[0] = 1'b0;
    repeat (14) step();
    wr(1'b1, 32'h01);
    peek(1'b1, v); chk("w1c_alone", v, 32'h0);

    // Unmasking an already pending bit
    press_btn(1);
    peek(1'b1, v); chk("pend_02", v, 32'h02);
    chk("irq_pend_masked", {31'h0, irq}, 32'h0);
    wr(1'b0, 32'h02);
    chk("unmask_lag", {31'h0, irq}, 32'h0);
    step();
    chk("unmask_irq", {31'h0, irq}, 32'h1);

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      we = ($urandom_range(0, 7) == 0);
      rd_en = ($urandom_range(0, 7) == 0);
      addr = $urandom_range(0, 1);
      Peripheral_in = $urandom;
      if ($urandom_range(0, 15) == 0) sw_raw = 8'($urandom);
      if ($urandom_range(0, 11) == 0) btn_raw[$urandom_range(0, 4)] ^= 1'b1;
    end
    step();
    we = 1'b0; rd_en = 1'b0; btn_raw = 5'h00; Peripheral_in = 32'h0;
    repeat (14) step();

    // Reset mid-operation with everything pending and unmasked
    wr(1'b0, 32'h1F);
    btn_raw = 5'h1F;
    repeat (14) step();
    btn_raw = 5'h00;
    repeat (14) step();
    peek(1'b1, v); chk("pend_1F", v, 32'h1F);
    chk("irq_all", {31'h0, irq}, 32'h1);
    sw_raw = 8'h3C;
    repeat (14) step();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_irq_now", {31'h0, irq}, 32'h0);
    chk("rst_out_now", Peripheral_out, 32'h0);
    step();
    rst = 1'b0;
    repeat (7) step();
    peek(1'b0, v); chk("post_rst_sw_early", {24'h0, v[7:0]}, 32'h0);
    step();
    peek(1'b0, v); chk("post_rst_sw_2ticks", {24'h0, v[7:0]}, 32'h3C);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
